// File: rtl/button_event_unit.sv
// button_event_unit: per-lane sync, integrating debounce, press/release pulses and hold flag.
// Define BTN_AUTOREPEAT_EN to build auto-repeat press pulses while a lane is held.
module button_event_unit #(
  parameter int NUM_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES = 200000,
  parameter int REPEAT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_held
);
  localparam logic [15:0] DLAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HMAX = 24'(HOLD_CYCLES);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    logic [1:0] sync;
    logic stable, held, press, rel, s, flip, stable_n, rep;
    logic [15:0] dcnt;
    logic [23:0] hcnt, hcnt_n;
    assign s = sync[1];
    assign flip = (s != stable) && (dcnt == DLAST);
    assign stable_n = flip ? s : stable;
    assign hcnt_n = !stable ? '0 : (hcnt == HMAX) ? hcnt : hcnt + 24'd1;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [23:0] RLAST = 24'(REPEAT_CYCLES - 1);
    logic [23:0] rcnt;
    always_ff @(posedge clk)
      rcnt <= (!reset || !held || rcnt == RLAST) ? '0 : rcnt + 24'd1;
    // a wrap on the release edge must not collide with the release pulse
    assign rep = held && (rcnt == RLAST) && stable_n;
`else
    assign rep = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync <= '0;
        stable <= 1'b0;
        dcnt <= '0;
        hcnt <= '0;
        held <= 1'b0;
        press <= 1'b0;
        rel <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw[i]};
        stable <= stable_n;
        dcnt <= (s == stable || flip) ? '0 : dcnt + 16'd1;
        hcnt <= hcnt_n;
        held <= stable_n && (hcnt_n == HMAX);
        press <= enable && ((flip && s) || rep);
        rel <= flip && !s;
      end
    end
    assign btn_level[i] = stable;
    assign btn_press[i] = press;
    assign btn_release[i] = rel;
    assign btn_held[i] = held;
  end
endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit: randomized and directed stimulus against a sample-window reference model.
module tb_button_event_unit;
  localparam int N = 5, D = 4, H = 10, R = 3;
  typedef struct packed {
    logic [N-1:0] level, press, rel, held;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_held;
  exp_t sbq[$];
  logic [N-1:0] hq[$];
  logic [N-1:0] st = '0;
  int rise[N];
  int cyc = 0, tests = 0, fails = 0;

  button_event_unit #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .enable(enable),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  // A lane's stable level flips once the last D synchronized samples all disagree with it.
  task automatic model();
    exp_t e;
    bit acc;
    e = '0;
    cyc++;
    if (!reset) begin
      hq.delete();
      for (int j = 0; j < D + 2; j++) hq.push_back('0);
      st = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        acc = 1;
        for (int j = hq.size() - 1 - D; j <= hq.size() - 2; j++)
          if (hq[j][i] == st[i]) acc = 0;
        if (acc) begin
          st[i] = ~st[i];
          if (st[i]) begin
            rise[i] = cyc;
            e.press[i] = enable;
          end else e.rel[i] = 1'b1;
        end
        e.level[i] = st[i];
        e.held[i] = st[i] && (cyc - rise[i] >= H);
`ifdef BTN_AUTOREPEAT_EN
        if (st[i] && (cyc - rise[i] > H) && ((cyc - rise[i] - H) % R == 0) && enable)
          e.press[i] = 1'b1;
`endif
      end
      hq.push_back(btn_raw);
      void'(hq.pop_front());
    end
    sbq.push_back(e);
  endtask

  task automatic step(input logic rst_n, input logic [N-1:0] raw, input logic en);
    reset = rst_n;
    btn_raw = raw;
    enable = en;
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic [N-1:0] raw, input logic en);
    for (int c = 0; c < n; c++) step(1'b1, raw, en);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      tests++;
      if ({btn_level, btn_press, btn_release, btn_held} !== e) begin
        fails++;
        $display("FAIL outputs cyc=%0d lvl/prs/rel/hld got %b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, btn_level, btn_press, btn_release, btn_held, e.level, e.press, e.rel, e.held);
      end
      tests++;
      if ((btn_press & btn_release) !== '0) begin
        fails++;
        $display("FAIL press_release_overlap cyc=%0d got %b want 0", cyc, btn_press & btn_release);
      end
    end
  end

  initial begin
    logic [N-1:0] raw;
    logic en;
    for (int c = 0; c < 3; c++) step(1'b0, 5'b11111, 1'b1);
    hold(10, 5'b11111, 1'b1);
    hold(10, 5'b00000, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b1, {4'b0, ~c[0]}, 1'b1);
    hold(10, 5'b00001, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(3, 5'b00001, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(4, 5'b00001, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(10, 5'b00010, 1'b0);
    hold(10, 5'b00000, 1'b1);
    hold(25, 5'b00100, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(10, 5'b11000, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(20, 5'b00001, 1'b1);
    hold(10, 5'b00001, 1'b0);
    hold(5, 5'b00001, 1'b1);
    hold(10, 5'b00000, 1'b1);
    hold(8, 5'b00100, 1'b1);
    for (int c = 0; c < 2; c++) step(1'b0, 5'b00100, 1'b1);
    hold(25, 5'b00100, 1'b1);
    raw = '0;
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, (c < 1500) ? 7 : 19) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 15) == 0) en = ~en;
      step($urandom_range(0, 299) != 0, raw, en);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_event_unit.md
Name: button_event_unit

Overview:
- Input conditioning stage that sits directly upstream of the game controller. It turns raw Basys pushbutton levels (btnL/R/U/D/C) into clean per-button events.
- Per-button pipeline: 2-flop synchronizer, integrating debounce counter, edge detector, hold detector.
- Outputs are one-cycle press/release pulses, a debounced level and a hold flag, all in the controller's clock domain. They replace the fixed-rate debounce pulses the controller samples today.
- A controller-driven enable masks press events while the game locks out controls.

Parameters:
- NUM_BTN, 5, number of independent button lanes.
- DEBOUNCE_CYCLES, 1024, consecutive clk cycles a synchronized input must differ from the stable state before being accepted; legal range 2..65535.
- HOLD_CYCLES, 200000, consecutive cycles of stable-high before btn_held asserts; legal range DEBOUNCE_CYCLES..2^24-1.
- REPEAT_CYCLES, 50000, auto-repeat period; used only when BTN_AUTOREPEAT_EN is defined.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, synchronous, active-low (0 = reset), sampled on posedge clk.
- btn_raw, input, NUM_BTN, asynchronous raw button levels; bit i = lane i.
- enable, input, 1, 1 = press events permitted; driven from the controller's controls-enable.
- btn_level, output, NUM_BTN, debounced stable level.
- btn_press, output, NUM_BTN, one-cycle pulse on accepted 0->1.
- btn_release, output, NUM_BTN, one-cycle pulse on accepted 1->0.
- btn_held, output, NUM_BTN, high while the lane has been stable-high for at least HOLD_CYCLES.

Behaviour:
- Reset (reset==0 at a posedge):
  - All sync flops, stable states, debounce counters and hold counters are cleared to 0.
  - btn_level, btn_press, btn_release and btn_held are all 0 in the following cycle.
  - Reset mid-debounce or mid-hold discards all progress; no pulse is emitted for the interrupted transition.
- Synchronizer: s_i = btn_raw[i] through two flops.
- Debounce, per lane, with counter dcnt (16 bit):
  - If s_i == stable_i: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: stable_i <= s_i; dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES returns dcnt to 0 and produces no output activity.
- Latency: let edge k be the first posedge that samples the new raw level, held steady from then on. btn_level changes after edge k+1+DEBOUNCE_CYCLES. The press/release pulse is registered on that same edge, so it is coincident with the first cycle of the new level.
- btn_press[i] = 1 for exactly one cycle when stable_i goes 0->1 and enable==1 on that edge.
  - If enable==0 on that edge, the press is dropped permanently; it is not deferred.
- btn_release[i] = 1 for exactly one cycle when stable_i goes 1->0. Release is not gated by enable.
- Hold, per lane, with counter hcnt (24 bit, saturating):
  - Cleared while stable_i==0.
  - Increments each cycle while stable_i==1 and saturates at HOLD_CYCLES.
  - btn_held[i] = (hcnt == HOLD_CYCLES), registered.
  - btn_held drops in the same cycle that btn_release pulses.
- Lanes are fully independent. Simultaneous transitions on several lanes produce pulses on all of them in the same cycle.
- btn_press and btn_release are never both high on one lane.
- btn_level is never gated by enable.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each lane gets a repeat counter rcnt, cleared whenever btn_held[i]==0.
  - While btn_held[i]==1, rcnt counts 0..REPEAT_CYCLES-1 and wraps.
  - On each wrap, btn_press[i] pulses for one cycle if enable==1. The first repeat pulse occurs REPEAT_CYCLES cycles after btn_held rises.
  - Repeat pulses are suppressed when enable==0, but rcnt keeps running.
- Undefined:
  - No repeat logic is built; REPEAT_CYCLES is ignored.
  - btn_press pulses at most once per accepted 0->1 transition.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, NUM_BTN=5):
- Reset: hold reset=0 for 3 cycles with btn_raw=5'b11111. Release reset and keep raw high. Required: all outputs 0 during reset; btn_level=5'b11111 and btn_press=5'b11111 for one cycle, 6 cycles after the first post-reset edge.
- Bounce: raw[0] toggles 1,0,1,0 each cycle, then stays 1. Required: no pulse during bouncing; one btn_press[0] 6 cycles after the last 0->1; btn_level[0]=1.
- Gating: enable=0 while raw[1] settles high. Required: btn_level[1]=1, btn_press[1] never pulses. Then set enable=1 and drop raw[1]. Required: one btn_release[1] pulse.
- Hold: raw[2] held high. Required: btn_held[2] rises 10 cycles after btn_level[2] rises; on release it clears coincident with btn_release[2].
- Simultaneous press: raw[3] and raw[4] rise on the same edge. Required: btn_press[3] and btn_press[4] pulse in the same cycle.
- Auto-repeat (macro defined): press held past btn_held. Required: btn_press pulses every 3 cycles. With enable=0: no pulses. Macro undefined: exactly one pulse.
